// File: rtl/NetworkPkg.sv
// Shared network types: ring packet layout and injection-head FSM states.
`ifndef ID_SIZE
`define ID_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 128
`endif
`ifndef NUMNODES
`define NUMNODES 3
`endif

package NetworkPkg;

    localparam int ID_W          = `ID_SIZE;
    localparam int DATA_W        = `DATA_WIDTH;
    localparam int NUM_NODES_DEF = `NUMNODES;

    typedef struct packed {
        logic [`ID_SIZE-1:0]    src;
        logic [`ID_SIZE-1:0]    dest;
        logic [`DATA_WIDTH-1:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        INJ_EMPTY = 2'd0,
        INJ_WAIT  = 2'd1,
        INJ_STALL = 2'd2
    } inj_state_t;

endpackage

// File: rtl/inj_queue.sv
// Circular buffer with push, pop, head and occupancy. Callers guarantee
// push only when not full and pop only when not empty; no policy lives here.
module inj_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy disambiguates full from empty.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_occ    <= {OCC_W{1'b0}};
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_occupancy = r_occ;

endmodule

// File: rtl/ring_inject_port.sv
// Per-node ring injection stage: stamps the source ID, drops illegal
// destinations, queues packets and presents the head to the ring. Tracks
// head starvation and counts packets the ring has taken.
module ring_inject_port
    import NetworkPkg::*;
#(
    parameter int NODE_ID     = 0,
    parameter int NUM_NODES   = NUM_NODES_DEF,
    parameter int DEPTH       = 4,
    parameter int STALL_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   core_valid,
    input  logic [ID_W-1:0]        core_dest,
    input  logic [DATA_W-1:0]      core_data,
    output logic                   core_ready,
    output logic [$bits(pkt_t)-1:0] ring_pkt,
    output logic                   ring_valid,
    input  logic                   ring_accept,
    input  logic                   ring_full,
    output logic                   stall_alarm,
    output logic                   bad_dest,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [15:0]            inj_count
);

    localparam int OCC_W  = $clog2(DEPTH) + 1;
    localparam int CNT_W  = $clog2(STALL_LIMIT) + 1;
    localparam int PKT_W  = $bits(pkt_t);
    localparam logic [OCC_W-1:0] FULL_CNT  = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic             r_core_ready;
    logic             r_bad_dest;
    logic [15:0]      r_inj_count;
    inj_state_t       r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_stall_alarm;

    logic             w_take;
    logic             w_legal;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    pkt_t             w_wpkt;
    pkt_t             w_head;
    logic [OCC_W-1:0] w_occ;
    logic [OCC_W-1:0] w_occ_next;
    logic [CNT_W-1:0] w_cnt_sat;

    // ring_full is status only and deliberately does not gate the handshake.
    logic             w_unused_full;
    assign w_unused_full = ring_full;

    assign w_take  = core_valid && r_core_ready;
    assign w_legal = (core_dest != ID_W'(NODE_ID)) && (32'(core_dest) < NUM_NODES);
    assign w_push  = w_take && w_legal;
    assign w_valid = (w_occ != {OCC_W{1'b0}});
    assign w_pop   = w_valid && ring_accept;

    assign w_wpkt.src  = ID_W'(NODE_ID);
    assign w_wpkt.dest = core_dest;
    assign w_wpkt.data = core_data;

    inj_queue #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_queue (
        .clk         (clk),
        .rst_l       (rst_l),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_wdata     (w_wpkt),
        .o_head      (w_head),
        .o_occupancy (w_occ)
    );

    // Next occupancy, needed for ready and for the EMPTY/WAIT choice on pop.
    always_comb begin
        w_occ_next = w_occ;
        if (w_push && !w_pop) begin
            w_occ_next = w_occ + OCC_W'(1);
        end else if (w_pop && !w_push) begin
            w_occ_next = w_occ - OCC_W'(1);
        end else begin
            w_occ_next = w_occ;
        end
    end

    assign w_cnt_sat = (r_stall_cnt == CNT_MAX) ? r_stall_cnt : r_stall_cnt + CNT_W'(1);

    // Head FSM: measures how long the head waits and raises the stall alarm.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state       <= INJ_EMPTY;
            r_stall_cnt   <= {CNT_W{1'b0}};
            r_stall_alarm <= 1'b0;
        end else begin
            case (r_state)
                INJ_EMPTY: begin
                    r_stall_cnt   <= {CNT_W{1'b0}};
                    r_stall_alarm <= 1'b0;
                    if (w_push) begin
                        r_state <= INJ_WAIT;
                    end else begin
                        r_state <= INJ_EMPTY;
                    end
                end
                INJ_WAIT, INJ_STALL: begin
                    if (w_pop) begin
                        r_stall_cnt   <= {CNT_W{1'b0}};
                        r_stall_alarm <= 1'b0;
                        r_state       <= (w_occ_next == {OCC_W{1'b0}}) ? INJ_EMPTY : INJ_WAIT;
                    end else if (r_state == INJ_STALL || r_stall_cnt >= CNT_LAST) begin
                        r_stall_cnt   <= w_cnt_sat;
                        r_stall_alarm <= 1'b1;
                        r_state       <= INJ_STALL;
                    end else begin
                        r_stall_cnt   <= w_cnt_sat;
                        r_stall_alarm <= 1'b0;
                        r_state       <= INJ_WAIT;
                    end
                end
                default: begin
                    r_state       <= INJ_EMPTY;
                    r_stall_cnt   <= {CNT_W{1'b0}};
                    r_stall_alarm <= 1'b0;
                end
            endcase
        end
    end

    // Ready (from registered count only), sticky bad-destination flag and injected count.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_core_ready <= 1'b0;
            r_bad_dest   <= 1'b0;
            r_inj_count  <= 16'd0;
        end else begin
            r_core_ready <= (w_occ_next != FULL_CNT);
            if (w_take && !w_legal) begin
                r_bad_dest <= 1'b1;
            end
            if (w_pop) begin
                r_inj_count <= r_inj_count + 16'd1;
            end
        end
    end

    assign core_ready  = r_core_ready;
    assign ring_valid  = w_valid;
    assign ring_pkt    = w_valid ? w_head : {PKT_W{1'b0}};
    assign stall_alarm = r_stall_alarm;
    assign bad_dest    = r_bad_dest;
    assign occupancy   = w_occ;
    assign inj_count   = r_inj_count;

endmodule

// File: tb/tb_ring_inject_port.sv
// Self-checking bench for ring_inject_port: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_ring_inject_port;
    import NetworkPkg::*;

    localparam int NODE_ID     = 0;
    localparam int NUM_NODES   = 3;
    localparam int DEPTH       = 4;
    localparam int STALL_LIMIT = 16;
    localparam int OCC_W       = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst_l;
    logic                 core_valid;
    logic [ID_W-1:0]      core_dest;
    logic [DATA_W-1:0]    core_data;
    logic                 core_ready;
    logic [$bits(pkt_t)-1:0] ring_pkt;
    logic                 ring_valid;
    logic                 ring_accept;
    logic                 ring_full;
    logic                 stall_alarm;
    logic                 bad_dest;
    logic [OCC_W-1:0]     occupancy;
    logic [15:0]          inj_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    pkt_t        mq[$];
    logic [15:0] m_inj;
    bit          m_bad;
    int          m_wait;
    bit          m_in_reset;

    ring_inject_port #(
        .NODE_ID(NODE_ID), .NUM_NODES(NUM_NODES), .DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk(clk), .rst_l(rst_l), .core_valid(core_valid), .core_dest(core_dest),
        .core_data(core_data), .core_ready(core_ready), .ring_pkt(ring_pkt),
        .ring_valid(ring_valid), .ring_accept(ring_accept), .ring_full(ring_full),
        .stall_alarm(stall_alarm), .bad_dest(bad_dest), .occupancy(occupancy),
        .inj_count(inj_count)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return !m_in_reset && (mq.size() != DEPTH);
    endfunction

    function automatic pkt_t m_head();
        pkt_t z;
        z = '0;
        if (mq.size() != 0) z = mq[0];
        return z;
    endfunction

    function automatic bit m_alarm();
        return m_wait >= STALL_LIMIT;
    endfunction

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic tick();
        pkt_t p;
        bit   rdy;
        rdy = m_ready();
        if (!rst_l) begin
            mq.delete();
            m_inj = 16'd0; m_bad = 1'b0; m_wait = 0; m_in_reset = 1'b1;
        end else begin
            if (mq.size() != 0 && ring_accept) begin
                void'(mq.pop_front());
                m_inj  = m_inj + 16'd1;
                m_wait = 0;
            end else if (mq.size() != 0) begin
                m_wait++;
            end
            if (core_valid && rdy) begin
                if (int'(core_dest) != NODE_ID && int'(core_dest) < NUM_NODES) begin
                    p.src = ID_W'(NODE_ID); p.dest = core_dest; p.data = core_data;
                    mq.push_back(p);
                end else begin
                    m_bad = 1'b1;
                end
            end
            if (mq.size() == 0) m_wait = 0;
            m_in_reset = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_valid = 1'b0; core_dest = '0; core_data = '0; ring_accept = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0; ring_full = 1'b0; idle_inputs();
        tick(); tick();
        n_cmp++; if (core_ready !== 1'b0) begin n_fail++; $display("FAIL reset_core_ready got %0b want 0", core_ready); end
        n_cmp++; if (ring_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ring_valid got %0b want 0", ring_valid); end
        n_cmp++; if (ring_pkt !== '0) begin n_fail++; $display("FAIL reset_ring_pkt got %h want 0", ring_pkt); end
        n_cmp++; if (stall_alarm !== 1'b0 || bad_dest !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %0b%0b want 00", stall_alarm, bad_dest); end
        n_cmp++; if (occupancy !== '0 || inj_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", occupancy, inj_count); end
        rst_l = 1'b1;
        tick();
        n_cmp++; if (core_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %0b want 1", core_ready); end
    endtask

    task automatic test_single();
        pkt_t want;
        core_valid = 1'b1; core_dest = ID_W'(2); core_data = DATA_W'(128'h1234);
        tick();
        idle_inputs();
        want.src = ID_W'(0); want.dest = ID_W'(2); want.data = DATA_W'(128'h1234);
        n_cmp++; if (ring_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", ring_valid); end
        n_cmp++; if (ring_pkt !== want || want !== m_head()) begin n_fail++; $display("FAIL single_pkt got %h want %h", ring_pkt, want); end
        ring_accept = 1'b1;
        tick();
        idle_inputs();
        n_cmp++; if (ring_valid !== 1'b0 || inj_count !== m_inj || m_inj !== 16'd1) begin n_fail++; $display("FAIL single_pop got v=%0b cnt=%0d want v=0 cnt=1", ring_valid, inj_count); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            core_valid = 1'b1; core_dest = ID_W'(1); core_data = DATA_W'(i);
            tick();
        end
        n_cmp++; if (core_ready !== 1'b0 || occupancy !== OCC_W'(4)) begin n_fail++; $display("FAIL fill_full got rdy=%0b occ=%0d want rdy=0 occ=4", core_ready, occupancy); end
        core_data = DATA_W'(5);
        tick();
        idle_inputs();
        n_cmp++; if (occupancy !== OCC_W'(mq.size()) || mq.size() != 4) begin n_fail++; $display("FAIL fill_fifth got occ=%0d want 4", occupancy); end
        for (int i = 1; i <= 4; i++) begin
            pkt_t h;
            h = pkt_t'(ring_pkt);
            n_cmp++; if (h.data !== DATA_W'(i) || ring_pkt !== m_head()) begin n_fail++; $display("FAIL drain_order got %0d want %0d", h.data, i); end
            ring_accept = 1'b1;
            tick();
        end
        idle_inputs();
        n_cmp++; if (occupancy !== '0 || ring_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got occ=%0d want 0", occupancy); end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 4; i++) begin
            core_valid = 1'b1; core_dest = ID_W'(2); core_data = DATA_W'($urandom);
            tick();
        end
        core_data = DATA_W'(16'hBEEF); ring_accept = 1'b1;
        tick();
        idle_inputs();
        n_cmp++; if (occupancy !== OCC_W'(3) || occupancy !== OCC_W'(mq.size())) begin n_fail++; $display("FAIL full_pushpop got occ=%0d want 3", occupancy); end
        ring_accept = 1'b1;
        tick();
        core_valid = 1'b1; core_dest = ID_W'(1); core_data = DATA_W'(16'hCAFE);
        tick();
        idle_inputs();
        n_cmp++; if (occupancy !== OCC_W'(2) || ring_pkt !== m_head()) begin n_fail++; $display("FAIL simul_pushpop got occ=%0d want 2", occupancy); end
        ring_accept = 1'b1;
        tick(); tick();
        idle_inputs();
    endtask

    task automatic test_stall();
        int rise;
        rise = -1;
        core_valid = 1'b1; core_dest = ID_W'(1); core_data = DATA_W'($urandom);
        tick();
        idle_inputs();
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (stall_alarm === 1'b1 && rise < 0) rise = c;
            n_cmp++; if (stall_alarm !== m_alarm()) begin n_fail++; $display("FAIL stall_track cyc=%0d got %0b want %0b", c, stall_alarm, m_alarm()); end
        end
        n_cmp++; if (rise != STALL_LIMIT) begin n_fail++; $display("FAIL stall_rise got %0d want %0d", rise, STALL_LIMIT); end
        ring_accept = 1'b1;
        tick();
        idle_inputs();
        n_cmp++; if (stall_alarm !== 1'b0 || ring_valid !== 1'b0) begin n_fail++; $display("FAIL stall_clear got %0b want 0", stall_alarm); end
    endtask

    task automatic test_bad_dest();
        core_valid = 1'b1; core_dest = ID_W'(0); core_data = DATA_W'(7);
        tick();
        core_dest = ID_W'(5);
        tick();
        idle_inputs();
        n_cmp++; if (occupancy !== '0 || bad_dest !== 1'b1 || m_bad !== 1'b1) begin n_fail++; $display("FAIL bad_drop got occ=%0d bad=%0b want 0/1", occupancy, bad_dest); end
        core_valid = 1'b1; core_dest = ID_W'(1); core_data = DATA_W'(9);
        tick();
        idle_inputs();
        n_cmp++; if (occupancy !== OCC_W'(1) || ring_pkt !== m_head() || bad_dest !== 1'b1) begin n_fail++; $display("FAIL bad_then_legal got occ=%0d bad=%0b want 1/1", occupancy, bad_dest); end
        ring_accept = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            core_valid = 1'b1; core_dest = ID_W'(2); core_data = DATA_W'($urandom);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 16; c++) tick();
        n_cmp++; if (stall_alarm !== 1'b1 || occupancy !== OCC_W'(3)) begin n_fail++; $display("FAIL pre_reset got alarm=%0b occ=%0d want 1/3", stall_alarm, occupancy); end
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        n_cmp++; if (core_ready !== 1'b0 || ring_valid !== 1'b0 || ring_pkt !== '0 || stall_alarm !== 1'b0 ||
                     bad_dest !== 1'b0 || occupancy !== '0 || inj_count !== 16'd0) begin
            n_fail++; $display("FAIL midreset got rdy=%0b v=%0b sa=%0b bd=%0b occ=%0d cnt=%0d want all 0",
                               core_ready, ring_valid, stall_alarm, bad_dest, occupancy, inj_count);
        end
        ring_accept = 1'b1;
        tick(); tick();
        ring_accept = 1'b0;
        n_cmp++; if (inj_count !== 16'd0 || occupancy !== '0 || core_ready !== 1'b1) begin n_fail++; $display("FAIL accept_empty got cnt=%0d occ=%0d want 0/0", inj_count, occupancy); end
    endtask

    task automatic test_random();
        int pct;
        pct = 50;
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) pct = (c % 180 == 60) ? 0 : int'($urandom_range(10, 90));
            core_valid  = ($urandom_range(0, 99) < 60);
            core_dest   = ID_W'($urandom_range(0, 5));
            core_data   = {$urandom, $urandom, $urandom, $urandom};
            ring_accept = ($urandom_range(0, 99) < pct);
            ring_full   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 299) == 0) rst_l = 1'b0;
            tick();
            rst_l = 1'b1;
            n_cmp++;
            if (core_ready !== m_ready() || ring_valid !== (mq.size() != 0) || ring_pkt !== m_head() ||
                occupancy !== OCC_W'(mq.size()) || inj_count !== m_inj || bad_dest !== m_bad ||
                stall_alarm !== m_alarm()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got rdy=%0b v=%0b occ=%0d cnt=%0d bd=%0b sa=%0b want rdy=%0b occ=%0d cnt=%0d bd=%0b sa=%0b",
                         c, core_ready, ring_valid, occupancy, inj_count, bad_dest, stall_alarm,
                         m_ready(), mq.size(), m_inj, m_bad, m_alarm());
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_inj = 16'd0; m_bad = 1'b0; m_wait = 0; m_in_reset = 1'b1;
        test_reset();
        test_single();
        test_fill_drain();
        test_simul();
        test_stall();
        test_bad_dest();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_inject_port.md
Name: ring_inject_port

Overview:
Per-node injection stage that sits directly upstream of the ring interconnect. It takes packets from a core, stamps the source ID, queues them, and drives one node's packetSendIn/packetCoreIn pair. It pops a packet only when the ring asserts that node's recievedOut bit. It also watches for injection starvation and illegal destinations, and keeps an injected-packet counter for the software simulator.

Parameters:
NODE_ID, 0, ID stamped into pkt_t.src; also the illegal self-destination.
NUM_NODES, `NUMNODES, ring size; dest >= NUM_NODES is illegal.
DEPTH, 4, injection queue entries (power of 2, >= 2).
STALL_LIMIT, 16, consecutive unaccepted cycles before stall_alarm is raised.

Ports:
clk  in  1  clock
rst_l  in  1  reset: synchronous, active-low
core_valid  in  1  core offers a packet
core_dest  in  `ID_SIZE  destination node
core_data  in  `DATA_WIDTH  payload
core_ready  out  1  port can take a packet this cycle
ring_pkt  out  $bits(pkt_t)  head packet, to ring packetSendIn[NODE_ID]
ring_valid  out  1  head valid, to ring packetCoreIn[NODE_ID]
ring_accept  in  1  ring recievedOut[NODE_ID]; ring took ring_pkt this cycle
ring_full  in  1  ring full[NODE_ID]; status only, never gates the handshake
stall_alarm  out  1  head has waited STALL_LIMIT cycles
bad_dest  out  1  sticky: an illegal packet was dropped
occupancy  out  $clog2(DEPTH)+1  queued entry count
inj_count  out  16  packets accepted by the ring; wraps

Behaviour:
- Reset applies at the posedge clk where rst_l=0. It is synchronous and overrides all other activity, including mid-operation. The queue is flushed.
- Output values in reset: core_ready=0, ring_valid=0, ring_pkt='0, stall_alarm=0, bad_dest=0, occupancy=0, inj_count=0, FSM=EMPTY. core_ready returns to 1 on the first cycle after rst_l=1.
- core_ready = (occupancy != DEPTH). It uses the registered count only, so a same-cycle pop does not create a slot.
- Push happens when core_valid && core_ready:
  - legal dest: enqueue {src=NODE_ID, dest=core_dest, data=core_data}.
  - dest == NODE_ID or dest >= NUM_NODES: the packet is consumed and not enqueued. bad_dest sets and stays set until reset.
- Head presentation: ring_valid = (occupancy != 0), combinational from registered state. ring_pkt = head entry, and is '0 when empty.
- Latency: a push into an empty queue makes ring_valid=1 on the next cycle.
- Pop happens when ring_valid && ring_accept; the head advances at posedge and inj_count increments.
  - ring_accept while empty is ignored: no pointer or count change.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. occupancy is tracked separately, so full and empty are unambiguous.
- ring_pkt must hold stable while ring_valid=1 and no pop has occurred.
- Head FSM:
  - EMPTY: occupancy=0. Moves to WAIT on push.
  - WAIT: head presented, stall_cnt increments each cycle without a pop.
    - On pop: to EMPTY if occupancy becomes 0, else stay in WAIT with stall_cnt cleared.
    - When stall_cnt reaches STALL_LIMIT-1 with no pop: to STALL.
  - STALL: stall_alarm=1. On pop, stall_cnt clears and the FSM goes to WAIT or EMPTY as above.
- stall_cnt width is $clog2(STALL_LIMIT)+1. It saturates and never wraps.
- inj_count wraps from 0xFFFF to 0.

Decomposition:
- pkt_t {src, dest, data}, `ID_SIZE, `DATA_WIDTH and `NUMNODES stay in the shared NetworkPkg and Network.svh.
- Add to NetworkPkg: typedef enum {INJ_EMPTY, INJ_WAIT, INJ_STALL} inj_state_t.
- One sub-module, inj_queue: a parameterised circular buffer with push, pop, head, occupancy and no internal policy. The FSM, destination check and counters stay in ring_inject_port.

Test Plan:
1. Reset, then push dest=2, data=128'h1234 (NODE_ID=0, NUM_NODES=3) -> next cycle ring_valid=1, ring_pkt={0,2,128'h1234}. Pulse ring_accept -> ring_valid=0, inj_count=1.
2. Push 4 packets (data 1..4) with ring_accept=0 -> core_ready=0 after the 4th and occupancy=4; a 5th core_valid is not taken. Accept 4 times -> data 1,2,3,4 leave in order, then occupancy=0.
3. Full queue with simultaneous core_valid and ring_accept -> the pop occurs, the push is refused that cycle, occupancy=3. With occupancy=2, simultaneous push and pop -> occupancy stays 2.
4. Hold one packet unaccepted, STALL_LIMIT=16 -> stall_alarm rises exactly 16 cycles after ring_valid rose. Accept -> stall_alarm=0 the next cycle.
5. Push dest=0 (self), then dest=5 -> neither enqueued, occupancy=0, bad_dest=1 and held. Then a legal dest=1 push -> queued normally.
6. Assert rst_l=0 for one cycle with occupancy=3 and stall_alarm=1 -> all outputs return to reset values on that edge. ring_accept pulses while empty -> no change to inj_count.
